// File: rtl/timer_ctrl_if.sv
// Host-side command/status bundle for timer_ctrl.
// The ovf_cnt_out status field exists only when TIMER_CTRL_OVF_CNT_EN is defined.
interface timer_ctrl_if #(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 4
);
  logic               start_in;
  logic               stop_in;
  logic               mode_in;
  logic [WIDTH-1:0]   period_in;
  logic [PRESC_W-1:0] presc_in;
  logic               ack_in;
  logic               busy_out;
  logic               tick_out;
  logic [WIDTH-1:0]   count_out;
  logic               tc_out;
  logic               done_out;
`ifdef TIMER_CTRL_OVF_CNT_EN
  logic [3:0]         ovf_cnt_out;

  modport master (
    output start_in, stop_in, mode_in, period_in, presc_in, ack_in,
    input  busy_out, tick_out, count_out, tc_out, done_out, ovf_cnt_out
  );
  modport slave (
    input  start_in, stop_in, mode_in, period_in, presc_in, ack_in,
    output busy_out, tick_out, count_out, tc_out, done_out, ovf_cnt_out
  );
`else
  modport master (
    output start_in, stop_in, mode_in, period_in, presc_in, ack_in,
    input  busy_out, tick_out, count_out, tc_out, done_out
  );
  modport slave (
    input  start_in, stop_in, mode_in, period_in, presc_in, ack_in,
    output busy_out, tick_out, count_out, tc_out, done_out
  );
`endif
endinterface

// File: rtl/timer_ctrl.sv
// Gated interval timer: prescaler + WIDTH-bit counter sequenced by an IDLE/RUN/DONE FSM.
// Optional missed-acknowledge counter enabled by the TIMER_CTRL_OVF_CNT_EN macro.
module timer_ctrl #(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 4
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  timer_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [PRESC_W-1:0] presc_cnt_reg;
  logic [PRESC_W-1:0] presc_reg;
  logic [WIDTH-1:0]   count_reg;
  logic [WIDTH-1:0]   period_reg;
  logic               mode_reg;
  logic               done_reg;

  logic tick;
  logic tc;
  logic busy;
  logic start_accept;

  // stop_in outranks a start presented in the same cycle
  assign start_accept = (state_reg == IDLE) && bus.start_in && !bus.stop_in;

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (bus.stop_in) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (bus.start_in) state_next = RUN;
        RUN:     if (tc && !mode_reg) state_next = DONE;
        DONE:    if (bus.ack_in) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output decode: purely from registered state, no input paths
  always_comb begin
    busy = (state_reg == RUN);
    tick = busy && (presc_cnt_reg == presc_reg);
    tc   = tick && (count_reg == period_reg);
  end

  // Prescaler, counter, configuration latch and sticky done flag
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      presc_cnt_reg <= '0;
      presc_reg     <= '0;
      count_reg     <= '0;
      period_reg    <= '0;
      mode_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else if (bus.stop_in) begin
      presc_cnt_reg <= '0;
      count_reg     <= '0;
      done_reg      <= 1'b0;
    end else if (start_accept) begin
      mode_reg      <= bus.mode_in;
      period_reg    <= bus.period_in;
      presc_reg     <= bus.presc_in;
      presc_cnt_reg <= '0;
      count_reg     <= '0;
      done_reg      <= 1'b0;
    end else if (state_reg == RUN) begin
      presc_cnt_reg <= tick ? '0 : presc_cnt_reg + 1'b1;
      if (tick) begin
        count_reg <= tc ? '0 : count_reg + 1'b1;
      end
      // a completion in the same cycle as ack_in keeps the flag set
      if (tc) begin
        done_reg <= 1'b1;
      end else if (bus.ack_in) begin
        done_reg <= 1'b0;
      end
    end else begin
      presc_cnt_reg <= '0;
      count_reg     <= '0;
      if (bus.ack_in) begin
        done_reg <= 1'b0;
      end
    end
  end

`ifdef TIMER_CTRL_OVF_CNT_EN
  logic [3:0] ovf_cnt_reg;

  // Counts completions that land on an still-unacknowledged done flag
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ovf_cnt_reg <= 4'd0;
    end else if (start_accept) begin
      ovf_cnt_reg <= 4'd0;
    end else if (tc && done_reg && !bus.ack_in && (ovf_cnt_reg != 4'd15)) begin
      ovf_cnt_reg <= ovf_cnt_reg + 4'd1;
    end
  end

  assign bus.ovf_cnt_out = ovf_cnt_reg;
`endif

  assign bus.busy_out  = busy;
  assign bus.tick_out  = tick;
  assign bus.tc_out    = tc;
  assign bus.count_out = count_reg;
  assign bus.done_out  = done_reg;

endmodule
